// File: rtl/ps2_key_tx_if.sv
// Key-event handshake and PS/2 line bundle for the keyboard-side transmitter.
// The master side raises key events; the slave side drives the PS/2 lines.
interface ps2_key_tx_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_ext;
  logic       key_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       frame_done;

  modport master (
    output key_valid,
    output key_code,
    output key_release,
    output key_ext,
    input  key_ready,
    input  ps2_clk,
    input  ps2_data,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_release,
    input  key_ext,
    output key_ready,
    output ps2_clk,
    output ps2_data,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/ps2_key_tx.sv
// PS/2 device-side transmitter: turns key make/break events into
// [E0] [F0] code scan-code frames on ps2_clk / ps2_data.
module ps2_key_tx #(
  parameter int HALF_PERIOD = 2500,
  parameter int GAP_CYCLES  = 5000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_key_tx_if.slave  kif
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    GAP
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } key_evt_t;

  state_t        state_q, state_n;
  logic [HW-1:0] half_q, half_n;
  logic [GW-1:0] gap_q, gap_n;
  logic [3:0]    bit_q, bit_n;
  logic [1:0]    byte_q, byte_n;
  logic [10:0]   frame_q, frame_n;
  key_evt_t      evt_q, evt_n;
  logic          clk_q, clk_n;
  logic          data_q, data_n;

  logic [7:0]    cur_byte;
  logic [1:0]    n_bytes;
  logic          more;

  // Prefixes come first: E0 at index 0 when extended, then F0 on release.
  always_comb begin
    cur_byte = evt_q.code;
    unique case (1'b1)
      evt_q.ext && (byte_q == 2'd0): cur_byte = 8'hE0;
      evt_q.rel && (byte_q == {1'b0, evt_q.ext}): cur_byte = 8'hF0;
      default: cur_byte = evt_q.code;
    endcase
  end

  assign n_bytes = 2'd1 + {1'b0, evt_q.ext} + {1'b0, evt_q.rel};
  assign more    = byte_q < n_bytes;

  always_comb begin
    state_n = state_q;
    half_n  = half_q;
    gap_n   = gap_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    frame_n = frame_q;
    evt_n   = evt_q;
    clk_n   = clk_q;
    data_n  = data_q;

    unique case (state_q)
      IDLE: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (kif.key_valid) begin
          evt_n.code = kif.key_code;
          evt_n.rel  = kif.key_release;
          evt_n.ext  = kif.key_ext;
          byte_n     = 2'd0;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        frame_n = {1'b1, ~^cur_byte, cur_byte, 1'b0};
        byte_n  = byte_q + 2'd1;
        bit_n   = 4'd0;
        half_n  = '0;
        clk_n   = 1'b1;
        data_n  = 1'b0;
        state_n = HIGH;
      end
      HIGH: begin
        if (half_q == HALF_LAST) begin
          half_n  = '0;
          clk_n   = 1'b0;
          state_n = LOW;
        end else begin
          half_n = half_q + 1'b1;
        end
      end
      LOW: begin
        if (half_q == HALF_LAST) begin
          half_n = '0;
          clk_n  = 1'b1;
          if (bit_q == 4'd10) begin
            gap_n   = '0;
            data_n  = 1'b1;
            state_n = GAP;
          end else begin
            bit_n   = bit_q + 4'd1;
            frame_n = {1'b1, frame_q[10:1]};
            data_n  = frame_q[1];
            state_n = HIGH;
          end
        end else begin
          half_n = half_q + 1'b1;
        end
      end
      GAP: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_n   = '0;
          state_n = more ? LOAD : IDLE;
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        clk_n   = 1'b1;
        data_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '1;
      evt_q   <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      half_q  <= half_n;
      gap_q   <= gap_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      frame_q <= frame_n;
      evt_q   <= evt_n;
      clk_q   <= clk_n;
      data_q  <= data_n;
    end
  end

  assign kif.key_ready  = (state_q == IDLE);
  assign kif.busy       = (state_q != IDLE);
  assign kif.frame_done = (state_q == GAP) && (gap_q == '0);
  assign kif.ps2_clk    = clk_q;
  assign kif.ps2_data   = data_q;

endmodule

// File: doc/ps2_key_tx.md
Name: ps2_key_tx

Overview:
- PS/2 device-side transmitter (keyboard emulator). It turns key press/release events into PS/2 scan-code frames on ps2_clk/ps2_data.
- Sequencing: make = [E0] code; break = [E0] F0 code.
- Drives the existing PS/2 receiver / scan-code display path for loopback bring-up, and acts as the keyboard model in simulation.
- Device-to-host only; host-to-device inhibit/commands are out of scope.

Parameters:
- HALF_PERIOD, 2500: system clocks per ps2_clk half period (50 MHz -> 10 kHz PS/2 clock); must be >= 2.
- GAP_CYCLES, 5000: idle clocks (both lines high) after every frame; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key event request.
- key_code  in  8  scan code (without prefixes).
- key_release  in  1  1 = break (insert F0), 0 = make.
- key_ext  in  1  1 = extended key (prefix E0).
- key_ready  out  1  block idle; can accept an event.
- ps2_clk  out  1  PS/2 clock line (driven push-pull model; idle 1).
- ps2_data  out  1  PS/2 data line (idle 1).
- busy  out  1  = ~key_ready.
- frame_done  out  1  one-cycle pulse after the last low phase of each frame.

Behaviour:
- Reset (async, rst_n=0): ps2_clk=1, ps2_data=1, key_ready=1, busy=0, frame_done=0, state IDLE, all counters 0.
  - Reset mid-frame aborts the transaction immediately; no partial completion after release.
- Handshake: event accepted at posedge where key_valid && key_ready.
  - key_code, key_release and key_ext are latched at that edge.
  - key_ready=0 from the next cycle until the whole sequence (all frames + gaps) completes.
  - key_valid while not ready is ignored, not queued.
- Byte sequence per event: E0 (if ext), then F0 (if release), then key_code. 1-3 frames, in that order.
- Frame: 11 bits = start 0, data[0..7] LSB first, odd parity (= ~^byte), stop 1.
- States:
  - IDLE -> LOAD (accept).
  - LOAD -> HIGH: select next byte, build 11-bit shift register; 1 cycle.
  - HIGH -> LOW after HALF_PERIOD clocks.
  - LOW -> HIGH (next bit) or -> GAP after bit 10.
  - GAP -> LOAD (more bytes pending) or IDLE, after GAP_CYCLES.
- Bit timing:
  - On entry to HIGH, ps2_data takes the current bit (registered) while ps2_clk=1, held for HALF_PERIOD cycles.
  - LOW: ps2_clk=0 for HALF_PERIOD cycles, ps2_data unchanged.
  - ps2_data changes only while ps2_clk is high, at the start of each HIGH phase. The receiver samples on the falling edge.
- Cycle budget: frame = 22*HALF_PERIOD clocks; ps2_clk shows exactly 11 falling edges.
  - frame_done pulses on the first GAP cycle.
  - During LOAD and GAP: ps2_clk=1, ps2_data=1.
- Latency: accept at edge T; LOAD on cycle T+1; start bit on ps2_data at T+2.
  - Single-frame event: key_ready returns 1 at T+2+22*HALF_PERIOD+GAP_CYCLES.
  - Each additional frame adds 1+22*HALF_PERIOD+GAP_CYCLES.
- Counters: half-period counter width clog2(HALF_PERIOD); gap counter width clog2(GAP_CYCLES); bit index 0..10; byte index 0..2. All counters reset to 0 on every phase entry; no wrap is possible.
- key_code = F0 or E0 is transmitted verbatim (no special casing).

Test Plan (HALF_PERIOD=4, GAP_CYCLES=8):
- Reset/idle: rst_n=0 then 1, no valid -> ps2_clk=1, ps2_data=1, key_ready=1, no ps2_clk edges for 200 cycles.
- Make 0x1C (ext=0, rel=0), accepted at T:
  - bits sampled at ps2_clk falls = 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - exactly 11 falls; start bit at T+2; frame_done once; key_ready=1 at T+98.
- Break 0x1C: two frames, F0 (bits 0,0,0,0,0,1,1,1,1,1,1, parity 1) then 1C; 22 falls total; two frame_done pulses; 8-cycle high gap between frames.
- Extended break 0x75 (ext=1, rel=1): frames E0 (parity 0), F0 (parity 1), 75 (parity 0); data decodes to E0,F0,75 in order; key_ready=1 at T+2+3*97-1.
- Parity/edge: key_code 0x00 -> parity 1; key_code 0xFF -> parity 1. ps2_data never toggles while ps2_clk=0 (assertion).
- Robustness:
  - key_valid held high with changing key_code during a frame -> ignored; only the accepted byte is sent.
  - rst_n pulsed low at bit 5 -> lines high within the same cycle, key_ready=1, no further ps2_clk edges.
  - a new event after reset transmits a clean frame.
